// File: rtl/pipe_seq.sv
// pipe_seq: pipeline sequencer for the 4-stage core (IF, ID, EX, WB).
// Turns hazard-unit stalls, EX-stage branch/memory events and HALT into
// per-stage register enables, NOP flushes and a data-memory start pulse.
// It is the only source of PC and pipeline-register enables.
//
// State table
//   state | meaning
//   RUN   | normal issue; halt > mem_req > br_taken > hz_stall > idle
//   MEM   | waiting for mem_ack, pipeline frozen, timeout counter running
//   HALT  | frozen until resume (or only reset once err is set)
//   2'b11 | illegal; behaves as RUN idle and returns to RUN
//
// Parameters
//   CW        width of stall_cnt
//   TMO       MEM cycles without mem_ack before err (2..255)
// Ports
//   clk, rst_n                   clock, async active-low reset
//   hz_stall, br_taken, mem_req  hazard / EX-stage events
//   mem_ack                      one-cycle data-memory completion
//   halt, resume                 HALT opcode in EX, external restart
//   pc_we..exwb_we               stage register enables
//   ifid_flush, idex_flush       load NOP into IF/ID, ID/EX
//   mem_go                       registered memory start pulse
//   state                        RUN=00, MEM=01, HALT=10
//   err                          sticky memory timeout
//   stall_cnt                    saturating count of cycles with pc_we=0
module pipe_seq #(
   parameter int CW  = 8,
   parameter int TMO = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hz_stall,
   input  logic          br_taken,
   input  logic          mem_req,
   input  logic          mem_ack,
   input  logic          halt,
   input  logic          resume,
   output logic          pc_we,
   output logic          ifid_we,
   output logic          idex_we,
   output logic          exwb_we,
   output logic          ifid_flush,
   output logic          idex_flush,
   output logic          mem_go,
   output logic [1:0]    state,
   output logic          err,
   output logic [CW-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      MEM  = 2'b01,
      HALT = 2'b10
   } stateT;

   localparam logic [7:0]    TmoLast = 8'(TMO - 1);
   localparam logic [CW-1:0] CntMax  = '1;

   stateT      curState;
   stateT      nextState;
   logic [7:0] tmoCnt;
   logic       enterMem;
   logic       tmoHit;

   always_comb begin
      pc_we      = 1'b1;
      ifid_we    = 1'b1;
      idex_we    = 1'b1;
      exwb_we    = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      nextState  = RUN;
      enterMem   = 1'b0;
      tmoHit     = 1'b0;
      case (curState)
         RUN: begin
            if (halt) begin
               {pc_we, ifid_we, idex_we, exwb_we} = 4'b0000;
               nextState = HALT;
            end else if (mem_req) begin
               {pc_we, ifid_we, idex_we, exwb_we} = 4'b0000;
               nextState = MEM;
               enterMem  = 1'b1;
            end else if (br_taken) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
            end else if (hz_stall) begin
               // Bubble: hold PC and IF/ID, push a NOP into ID/EX.
               pc_we      = 1'b0;
               ifid_we    = 1'b0;
               idex_flush = 1'b1;
            end
         end
         MEM: begin
            // An ack on the last allowed cycle still counts as success.
            if (mem_ack) begin
               nextState = RUN;
            end else begin
               {pc_we, ifid_we, idex_we, exwb_we} = 4'b0000;
               if (tmoCnt == TmoLast) begin
                  nextState = HALT;
                  tmoHit    = 1'b1;
               end else begin
                  nextState = MEM;
               end
            end
         end
         HALT: begin
            // Once err is set, resume is ignored: only reset leaves HALT.
            if (resume && !err) begin
               nextState = RUN;
            end else begin
               {pc_we, ifid_we, idex_we, exwb_we} = 4'b0000;
               nextState = HALT;
            end
         end
         default: nextState = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         curState  <= RUN;
         mem_go    <= 1'b0;
         err       <= 1'b0;
         tmoCnt    <= 8'd0;
         stall_cnt <= '0;
      end else begin
         curState <= nextState;
         mem_go   <= enterMem;
         if (tmoHit) begin
            err <= 1'b1;
         end
         // Held at zero outside MEM so every MEM entry starts from 0.
         if (curState != MEM) begin
            tmoCnt <= 8'd0;
         end else if (tmoCnt != TmoLast) begin
            tmoCnt <= tmoCnt + 8'd1;
         end
         if (!pc_we && stall_cnt != CntMax) begin
            stall_cnt <= stall_cnt + CW'(1);
         end
      end
   end

   assign state = curState;

endmodule

// File: doc/pipe_seq.md
# pipe_seq

Pipeline sequencer for the 4-stage core (IF, ID, EX, WB). It turns the hazard unit's stall request, EX-stage branch and memory events, and the HALT opcode into per-stage register write-enables, flushes and a data-memory start pulse. It also keeps a saturating count of stall cycles. It sits between the hazard unit and the pipeline registers, and is the only source of PC and pipeline-register enables.

## Interface
- `CW`, 8, width of `stall_cnt`
- `TMO`, 16, maximum cycles spent in MEM without `mem_ack` before an error is raised; legal range 2..255
- `clk` in 1: rising-edge clock
- `rst_n` in 1: asynchronous, active-low reset
- `hz_stall` in 1: load-use hazard from the hazard unit (its `stall` output)
- `br_taken` in 1: EX branch resolved taken; held while EX is frozen
- `mem_req` in 1: instruction in EX needs data memory; held while EX is frozen
- `mem_ack` in 1: one-cycle completion pulse from data memory
- `halt` in 1: HALT opcode is in EX
- `resume` in 1: external restart request
- `pc_we`, `ifid_we`, `idex_we`, `exwb_we` out 1: stage register enables
- `ifid_flush`, `idex_flush` out 1: load a NOP into IF/ID or ID/EX on this edge
- `mem_go` out 1: registered one-cycle memory start pulse
- `state` out 2: RUN=00, MEM=01, HALT=10
- `err` out 1: sticky memory timeout flag
- `stall_cnt` out CW: saturating count of cycles with `pc_we`=0

## Operation
- FSM states: RUN, MEM, HALT. Encoding 11 is illegal and must go to RUN on the next edge; while in 11, enables follow the RUN-idle row.
- Enables and flushes are combinational from the state and inputs. `mem_go`, `err`, `stall_cnt`, the timeout counter and `state` are registered.
- RUN, priority from highest to lowest:
  - `halt`: all enables 0, no flush, next state HALT.
  - `mem_req`: all enables 0, next state MEM, `mem_go`=1 on the next cycle.
  - `br_taken`: all enables 1, `ifid_flush`=1, `idex_flush`=1, next state RUN.
  - `hz_stall`: `pc_we`=0, `ifid_we`=0, `idex_we`=1, `idex_flush`=1, `exwb_we`=1, next state RUN (bubble insertion).
  - Otherwise: all enables 1, no flush.
- MEM:
  - Timeout counter clears on entry and increments each MEM cycle.
  - Without `mem_ack`, all enables are 0.
  - When `mem_ack`=1, all enables are 1, then next state RUN. `br_taken`, `hz_stall` and `halt` are ignored that cycle.
  - If the counter reaches `TMO`-1 with no ack, then `err`←1 and next state HALT.
  - `mem_ack` outside MEM is ignored.
- HALT:
  - All enables 0.
  - When `resume`=1 and `err`=0, all enables are 1 for that cycle (retires HALT from EX), next state RUN.
  - When `err`=1, `resume` is ignored; only reset leaves the state.
- `stall_cnt` increments on every edge where `pc_we`=0 and holds at 2^CW−1. It is cleared only by reset.

## Timing
- Reset (asynchronous, `rst_n`=0) forces:
  - `state`=RUN, `mem_go`=0, `err`=0, `stall_cnt`=0, timeout counter 0.
  - With inputs at 0, the combinational outputs are all enables 1 and flushes 0.
- Reset in the middle of MEM or HALT aborts it immediately. No `mem_go` is produced after reset is released unless a new `mem_req` arrives.
- Latencies:
  - Hazard and branch responses are effective on the same edge (0-cycle).
  - `mem_go` is asserted exactly one cycle, in the first MEM cycle.
  - The minimum MEM occupancy is 1 cycle; `mem_ack` may coincide with `mem_go`.
- A `mem_ack` in the same cycle the count reaches `TMO`-1 counts as success (ack wins).
- `stall_cnt` updates one edge after the stalled cycle.

## Test plan
- Reset with `rst_n`=0, then release, all inputs 0 → `state`=00, all `*_we`=1, flushes 0, `stall_cnt`=0, `err`=0.
- `hz_stall`=1 for 1 cycle in RUN → that cycle `pc_we`=0, `ifid_we`=0, `idex_flush`=1, `exwb_we`=1; `stall_cnt`=1 afterwards.
- `mem_req`=1 held, with `mem_ack` pulsed 3 cycles after entering MEM → `mem_go` high only in the first MEM cycle, enables 0 for 3 cycles, all 1 in the ack cycle, `state` back to 00; `stall_cnt`=4.
- `mem_req`=1 and `br_taken`=1 together, then ack → MEM first; in the next RUN cycle, `ifid_flush`=`idex_flush`=1.
- `TMO`=4, `mem_req` held with no ack → after 4 MEM cycles `err`=1, `state`=10; `resume`=1 gives no change; `rst_n` pulse clears `err`.
- `halt`=1, then `resume`=1 after 5 cycles → enables 0 for 6 cycles, all 1 on the resume cycle, `state`=00; `CW`=3 run with more than 7 stall cycles → `stall_cnt` holds at 7.
